// File: rtl/sm_iter_divider.sv
// Sign-magnitude restoring divider, one quotient bit per clock.
// A start/busy/done handshake frames each division.
module sm_iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int M  = WIDTH - 1;
    localparam int CW = $clog2(M + 1);

    typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;

    state_t         state, state_nx;
    logic           qs, rs, zf;
    logic [M-1:0]   d, q, q_nx;
    logic [M-1:0]   r, r_nx;
    logic [M:0]     r_sh;
    logic [CW-1:0]  cnt;
    logic           accept, last;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        busy     = (state == DIV);
        done     = (state == FIN);
        accept   = start && !busy;
        last     = zf || (cnt == '0);
        r_sh     = {r, q[M-1]};
        r_nx     = r_sh[M-1:0];
        q_nx     = {q[M-2:0], 1'b0};
        state_nx = state;
        // Partial remainder stays below D, so M bits hold it after restore
        if (r_sh >= {1'b0, d}) begin
            r_nx = M'(r_sh - {1'b0, d});
            q_nx = {q[M-2:0], 1'b1};
        end
        unique case (state)
            IDLE:    if (accept) state_nx = DIV;
            DIV:     if (last)   state_nx = FIN;
            FIN:     state_nx = accept ? DIV : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qs          <= 1'b0;
            rs          <= 1'b0;
            zf          <= 1'b0;
            d           <= '0;
            q           <= '0;
            r           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            qs  <= a[M] ^ b[M];
            rs  <= a[M];
            zf  <= (b[M-1:0] == '0);
            d   <= b[M-1:0];
            q   <= a[M-1:0];
            r   <= '0;
            cnt <= CW'(M - 1);
        end else if (state == DIV) begin
            if (zf) begin
                // Dividend is still intact in rs/q, returned unmodified
                quotient    <= {1'b0, {M{1'b1}}};
                remainder   <= {rs, q};
                div_by_zero <= 1'b1;
            end else begin
                r   <= r_nx;
                q   <= q_nx;
                cnt <= cnt - CW'(1);
                if (cnt == '0) begin
                    quotient    <= {qs & (|q_nx), q_nx};
                    remainder   <= {rs & (|r_nx), r_nx};
                    div_by_zero <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_sm_iter_divider.sv
// Randomised and directed checks of sm_iter_divider against
// a plain-arithmetic sign-magnitude division model.
module tb_sm_iter_divider;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    int npass  = 0;
    int ntotal = 0;
    logic [31:0] prev_q, prev_r;

    sm_iter_divider #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        ntotal++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eq, output logic [31:0] er,
                                  output logic ez);
        longint unsigned ma, mb, qm, rm;
        ma = longint'(x[30:0]);
        mb = longint'(y[30:0]);
        if (mb == 0) begin
            eq = 32'h7FFF_FFFF;
            er = x;
            ez = 1'b1;
        end else begin
            qm = ma / mb;
            rm = ma % mb;
            eq = (qm == 0) ? 32'h0 : {x[31] ^ y[31], qm[30:0]};
            er = (rm == 0) ? 32'h0 : {x[31], rm[30:0]};
            ez = 1'b0;
        end
    endfunction

    // Waits at negedges until done; returns cycles after accept and busy count
    task automatic wait_done(output int cyc, output int nb);
        cyc = 0;
        nb  = 0;
        while (!done && cyc < 40) begin
            if (busy) nb++;
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic do_div(input logic [31:0] x, input logic [31:0] y,
                          input string tag);
        logic [31:0] eq, er;
        logic ez;
        int cyc, nb, lat;
        model(x, y, eq, er, ez);
        lat = ez ? 1 : 31;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        check({tag, "_hold_q"}, quotient, prev_q);
        check({tag, "_hold_r"}, remainder, prev_r);
        wait_done(cyc, nb);
        check({tag, "_lat"}, cyc, lat);
        check({tag, "_busy"}, nb, lat);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_dbz"}, div_by_zero, ez);
        prev_q = quotient;
        prev_r = remainder;
        @(negedge clk);
        check({tag, "_pulse"}, done, 1'b0);
    endtask

    initial begin
        int cyc, nb, ndone;
        logic [31:0] x, y;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        prev_q = '0; prev_r = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_q", quotient, 32'h0);
        check("rst_r", remainder, 32'h0);
        check("rst_dbz", div_by_zero, 1'b0);
        rst = 1'b0;

        do_div(32'h0000_0064, 32'h0000_0007, "pos");
        do_div(32'h8000_0064, 32'h0000_0007, "negA");
        do_div(32'h0000_0064, 32'h8000_0007, "negB");
        do_div(32'h8000_0003, 32'h0000_0005, "negzero");
        do_div(32'h7FFF_FFFF, 32'h0000_0001, "max");
        do_div(32'h0000_0005, 32'h8000_0000, "dbz");
        do_div(32'h0000_0000, 32'h8000_0003, "zero_dvd");

        // start while busy is ignored; start in FIN is accepted
        @(negedge clk);
        a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        a = 32'd1; b = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, nb);
        check("ign_q", quotient, 32'd14);
        check("ign_r", remainder, 32'd2);
        a = 32'd9; b = 32'd2; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("fin_busy", busy, 1'b1);
        check("fin_hold_q", quotient, 32'd14);
        wait_done(cyc, nb);
        check("fin_lat", cyc, 31);
        check("fin_q", quotient, 32'd4);
        check("fin_r", remainder, 32'd1);

        // Reset mid-division aborts with no done pulse
        @(negedge clk);
        a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_q", quotient, 32'h0);
        check("abort_r", remainder, 32'h0);
        check("abort_dbz", div_by_zero, 1'b0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_nodone", ndone, 0);
        prev_q = '0;
        prev_r = '0;
        do_div(32'h0000_0064, 32'h0000_0007, "after_rst");

        for (int i = 0; i < 20; i++) begin
            x = $urandom;
            y = $urandom;
            unique case (i % 4)
                0: y[30:0] = 31'($urandom_range(1, 15));
                1: y[30:0] = 31'($urandom_range(0, 65535));
                2: y[30:0] = '0;
                default: ;
            endcase
            if (y[30:0] == '0 && x[30:0] == '0) x[30:0] = 31'd1;
            do_div(x, y, "rand");
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
